// File: rtl/ide_disk_resp.sv
// rtl/ide_disk_resp.sv - ATA PIO disk responder with a 256-word sector buffer and a one-word memory handshake
// Optional IDENTIFY DEVICE (0xEC) support is compiled in with IDE_IDENTIFY_EN.
module ide_disk_resp #(
    parameter int MEM_LAT_MAX = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    inout  wire  [15:0] ide_data_bus,
    input  logic        ide_dior,
    input  logic        ide_diow,
    input  logic [1:0]  ide_cs,
    input  logic [2:0]  ide_da,
    output logic        mem_req,
    output logic        mem_we,
    output logic [27:0] mem_lba,
    output logic [7:0]  mem_word,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int LW = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LAT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        XFER_RD,
        XFER_WR,
        FLUSH
    } state_t;

    state_t state, state_next;

    logic [2:0]    dior_sync, diow_sync;
    logic          dior_rise, diow_rise;
    logic          cmd_sel, ctl_sel, drive;
    logic [7:0]    wr_byte;
    logic          err, srst, ack_gap;
    logic [7:0]    err_reg, sec_count, status;
    logic [27:0]   lba;
    logic [3:0]    dev_top;
    logic [7:0]    ptr;
    logic [LW-1:0] lat_cnt;
    logic          bsy, drq, tf_wr, cmd_wr;
    logic          cmd_read, cmd_write, cmd_ident, cmd_ok;
    logic          rd_data_edge, wr_data_edge, last_rd, last_wr;
    logic          mem_ack_ok, mem_last, mem_timeout, more;
    logic          ident_mode;
    logic [15:0]   data_word, rd_word;
    logic          buf_we;
    logic [7:0]    buf_addr;
    logic [15:0]   buf_wdata;
    logic [15:0]   sector_buf [256];

    // Strobe synchronizers; bit 2 is the delayed copy used for trailing-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dior_sync <= 3'b111;
            diow_sync <= 3'b111;
        end else begin
            dior_sync <= {dior_sync[1:0], ide_dior};
            diow_sync <= {diow_sync[1:0], ide_diow};
        end
    end

    assign dior_rise = dior_sync[1] & ~dior_sync[2];
    assign diow_rise = diow_sync[1] & ~diow_sync[2];

    assign cmd_sel = (ide_cs == 2'b10);
    assign ctl_sel = (ide_cs == 2'b01) && (ide_da == 3'd6);
    assign wr_byte = ide_data_bus[7:0];

    assign bsy    = (state == FILL) || (state == FLUSH) || srst;
    assign drq    = ((state == XFER_RD) || (state == XFER_WR)) && !srst;
    assign status = {bsy, 1'b1, 1'b0, 1'b1, drq, 2'b00, err};

    assign tf_wr  = diow_rise && cmd_sel && !bsy && !drq;
    assign cmd_wr = tf_wr && (ide_da == 3'd7);

    assign cmd_read  = (wr_byte == 8'h20);
    assign cmd_write = (wr_byte == 8'h30);
`ifdef IDE_IDENTIFY_EN
    assign cmd_ident = (wr_byte == 8'hEC);
`else
    assign cmd_ident = 1'b0;
`endif
    assign cmd_ok = cmd_read || cmd_write || cmd_ident;

    assign rd_data_edge = dior_rise && cmd_sel && (ide_da == 3'd0);
    assign wr_data_edge = diow_rise && cmd_sel && (ide_da == 3'd0) && (state == XFER_WR) && !srst;
    assign last_rd      = (state == XFER_RD) && rd_data_edge && (ptr == 8'hFF);
    assign last_wr      = wr_data_edge && (ptr == 8'hFF);

    // mem_req drops for one cycle after every ack so each ack maps to exactly one word
    assign mem_req     = ((state == FILL) || (state == FLUSH)) && !ack_gap && !srst;
    assign mem_we      = (state == FLUSH);
    assign mem_lba     = lba;
    assign mem_wdata   = sector_buf[mem_word];
    assign mem_ack_ok  = mem_req && mem_ack;
    assign mem_last    = mem_ack_ok && (mem_word == 8'hFF);
    assign mem_timeout = mem_req && !mem_ack && (lat_cnt == LAT_LAST);
    assign more        = (sec_count != 8'h01);

`ifdef IDE_IDENTIFY_EN
    function automatic logic [15:0] ident_word(input logic [7:0] idx);
        case (idx)
            8'd0:    ident_word = 16'h0040;
            8'd1:    ident_word = 16'd16383;
            8'd3:    ident_word = 16'd16;
            8'd6:    ident_word = 16'd63;
            8'd49:   ident_word = 16'h0200;
            8'd60:   ident_word = 16'hFFFF;
            8'd61:   ident_word = 16'h0FFF;
            default: ident_word = 16'h0000;
        endcase
    endfunction

    // IDENTIFY data is generated on the fly instead of being copied into the buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ident_mode <= 1'b0;
        else if (srst)
            ident_mode <= 1'b0;
        else if (cmd_wr && cmd_ok)
            ident_mode <= cmd_ident;
    end

    assign data_word = ident_mode ? ident_word(ptr) : sector_buf[ptr];
`else
    assign ident_mode = 1'b0;
    assign data_word  = sector_buf[ptr];
`endif

    always_comb begin
        rd_word = 16'h0000;
        if (ctl_sel) begin
            rd_word = {8'h00, status};
        end else begin
            case (ide_da)
                3'd0:    rd_word = data_word;
                3'd1:    rd_word = {8'h00, err_reg};
                3'd2:    rd_word = {8'h00, sec_count};
                3'd3:    rd_word = {8'h00, lba[7:0]};
                3'd4:    rd_word = {8'h00, lba[15:8]};
                3'd5:    rd_word = {8'h00, lba[23:16]};
                3'd6:    rd_word = {8'h00, dev_top, lba[27:24]};
                default: rd_word = {8'h00, status};
            endcase
        end
    end

    assign drive        = !ide_dior && (cmd_sel || ctl_sel);
    assign ide_data_bus = drive ? rd_word : 16'hzzzz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_wr) begin
                    if (cmd_read)
                        state_next = FILL;
                    else if (cmd_write)
                        state_next = XFER_WR;
                    else if (cmd_ident)
                        state_next = XFER_RD;
                end
            end
            FILL: begin
                if (mem_timeout)
                    state_next = IDLE;
                else if (mem_last)
                    state_next = XFER_RD;
            end
            XFER_RD: begin
                if (last_rd)
                    state_next = (ident_mode || !more) ? IDLE : FILL;
            end
            XFER_WR: begin
                if (last_wr)
                    state_next = FLUSH;
            end
            FLUSH: begin
                if (mem_timeout)
                    state_next = IDLE;
                else if (mem_last)
                    state_next = more ? XFER_WR : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (srst)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err       <= 1'b0;
            err_reg   <= 8'h01;
            sec_count <= 8'h01;
            lba       <= 28'h0;
            dev_top   <= 4'hE;
            ptr       <= 8'h00;
            mem_word  <= 8'h00;
            lat_cnt   <= '0;
            ack_gap   <= 1'b0;
            srst      <= 1'b0;
        end else begin
            ack_gap <= mem_ack;
            if (diow_rise && ctl_sel)
                srst <= wr_byte[2];
            if (srst) begin
                err       <= 1'b0;
                err_reg   <= 8'h01;
                sec_count <= 8'h01;
                lba       <= 28'h0;
                dev_top   <= 4'hE;
                ptr       <= 8'h00;
                mem_word  <= 8'h00;
                lat_cnt   <= '0;
            end else begin
                if (tf_wr) begin
                    case (ide_da)
                        3'd2: sec_count   <= wr_byte;
                        3'd3: lba[7:0]    <= wr_byte;
                        3'd4: lba[15:8]   <= wr_byte;
                        3'd5: lba[23:16]  <= wr_byte;
                        3'd6: begin
                            dev_top    <= wr_byte[7:4];
                            lba[27:24] <= wr_byte[3:0];
                        end
                        3'd7: begin
                            if (cmd_ok) begin
                                err      <= 1'b0;
                                err_reg  <= 8'h00;
                                ptr      <= 8'h00;
                                mem_word <= 8'h00;
                            end else begin
                                err     <= 1'b1;
                                err_reg <= 8'h04;
                            end
                        end
                        default: ;
                    endcase
                end

                if (mem_req) begin
                    if (mem_ack) begin
                        mem_word <= mem_word + 8'd1;
                        lat_cnt  <= '0;
                    end else if (mem_timeout) begin
                        err     <= 1'b1;
                        err_reg <= 8'h10;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end else begin
                    lat_cnt <= '0;
                end

                if ((state == FLUSH) && mem_last) begin
                    sec_count <= sec_count - 8'd1;
                    lba       <= lba + 28'd1;
                end

                if ((state == XFER_RD) && rd_data_edge) begin
                    ptr <= ptr + 8'd1;
                    if ((ptr == 8'hFF) && !ident_mode) begin
                        sec_count <= sec_count - 8'd1;
                        lba       <= lba + 28'd1;
                    end
                end

                if (wr_data_edge)
                    ptr <= ptr + 8'd1;
            end
        end
    end

    assign buf_we    = ((state == FILL) && mem_ack_ok) || wr_data_edge;
    assign buf_addr  = (state == FILL) ? mem_word : ptr;
    assign buf_wdata = (state == FILL) ? mem_rdata : ide_data_bus;

    always_ff @(posedge clk) begin
        if (buf_we)
            sector_buf[buf_addr] <= buf_wdata;
    end

endmodule

// File: tb/tb_ide_disk_resp.sv
// tb/tb_ide_disk_resp.sv - scoreboard bench for ide_disk_resp with a latency-randomised backing store
module tb_ide_disk_resp;

    localparam int MEM_LAT_MAX = 1023;

    logic        clk = 1'b0;
    logic        reset_n;
    wire  [15:0] ide_data_bus;
    logic        ide_dior, ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;
    logic        mem_req, mem_we;
    logic [27:0] mem_lba;
    logic [7:0]  mem_word;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;

    logic [15:0] host_data;
    logic        host_oe;
    logic        mem_en;
    int unsigned mem_delay = 0, mem_wait = 0;
    int unsigned cyc = 0;
    int          n_checks = 0, n_fail = 0;

    logic [35:0] rd_log[$];
    logic [15:0] exp_rd_q[$];
    logic [51:0] wr_log[$];
    logic [51:0] exp_wr_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ide_data_bus = host_oe ? host_data : 16'hzzzz;

    ide_disk_resp #(.MEM_LAT_MAX(MEM_LAT_MAX)) dut (
        .clk(clk), .reset_n(reset_n), .ide_data_bus(ide_data_bus),
        .ide_dior(ide_dior), .ide_diow(ide_diow), .ide_cs(ide_cs), .ide_da(ide_da),
        .mem_req(mem_req), .mem_we(mem_we), .mem_lba(mem_lba), .mem_word(mem_word),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    function automatic logic [15:0] pat(input logic [27:0] l, input logic [7:0] w);
        return {l[7:0] ^ 8'hC3, w ^ l[15:8] ^ 8'h3C};
    endfunction

    // Backing store: one ack per request after 0..2 extra cycles; every served word is logged
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ack  = 1'b0;
            mem_wait = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && mem_en) begin
            if (mem_wait < mem_delay) begin
                mem_wait++;
            end else begin
                mem_wait  = 0;
                mem_delay = $urandom_range(0, 2);
                mem_ack   = 1'b1;
                if (mem_we) begin
                    wr_log.push_back({mem_lba, mem_word, mem_wdata});
                end else begin
                    mem_rdata = pat(mem_lba, mem_word);
                    rd_log.push_back({mem_lba, mem_word});
                    exp_rd_q.push_back(mem_rdata);
                end
            end
        end
    end

    task automatic host_wr(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] d);
        @(negedge clk);
        ide_cs = cs; ide_da = da; host_data = d; host_oe = 1'b1;
        repeat (2) @(negedge clk);
        ide_diow = 1'b0;
        repeat (3) @(negedge clk);
        ide_diow = 1'b1;
        repeat (4) @(negedge clk);
        host_oe = 1'b0; ide_cs = 2'b11;
    endtask

    task automatic host_rd(input logic [1:0] cs, input logic [2:0] da, output logic [15:0] d);
        @(negedge clk);
        ide_cs = cs; ide_da = da; ide_dior = 1'b0;
        repeat (3) @(negedge clk);
        d = ide_data_bus;
        ide_dior = 1'b1;
        repeat (4) @(negedge clk);
        ide_cs = 2'b11;
    endtask

    task automatic wr_reg(input logic [2:0] da, input logic [7:0] v);
        host_wr(2'b10, da, {8'h00, v});
    endtask

    task automatic rd_reg(input logic [2:0] da, output logic [7:0] v);
        logic [15:0] d;
        host_rd(2'b10, da, d);
        v = d[7:0];
    endtask

    task automatic wait_status(input logic [7:0] mask, input logic [7:0] want,
                               input int unsigned budget, output logic ok, output logic [7:0] st);
        int unsigned t0;
        t0 = cyc;
        ok = 1'b0;
        while (1) begin
            rd_reg(3'd7, st);
            if ((st & mask) == want) begin
                ok = 1'b1;
                break;
            end
            if (cyc - t0 > budget) break;
        end
    endtask

    task automatic test_reset;
        logic [7:0] v;
        logic [15:0] d;
        mem_en = 1'b0;
        wr_reg(3'd2, 8'h01); wr_reg(3'd3, 8'h20); wr_reg(3'd7, 8'h20);
        repeat (3) @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fill_req: mem_req %b want 1", mem_req); end
        rd_reg(3'd7, v);
        n_checks++; if (v !== 8'hD0) begin n_fail++; $display("FAIL fill_status: got %h want d0", v); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: mem_req %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: mem_we %b want 0", mem_we); end
        host_data = 16'h0000; host_oe = 1'b1; #1;
        n_checks++; if (ide_data_bus !== 16'h0000) begin n_fail++; $display("FAIL reset_hiz0: bus %h want 0000", ide_data_bus); end
        host_data = 16'hFFFF; #1;
        n_checks++; if (ide_data_bus !== 16'hFFFF) begin n_fail++; $display("FAIL reset_hiz1: bus %h want ffff", ide_data_bus); end
        host_oe = 1'b0;
        host_rd(2'b10, 3'd7, d);
        n_checks++; if (d[7:0] !== 8'h50) begin n_fail++; $display("FAIL reset_status: got %h want 50", d[7:0]); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd_reg(3'd1, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL reset_error: got %h want 01", v); end
        rd_reg(3'd2, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL reset_count: got %h want 01", v); end
        rd_reg(3'd3, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_lba0: got %h want 00", v); end
        rd_log.delete(); exp_rd_q.delete();
        mem_en = 1'b1;
    endtask

    task automatic test_read;
        logic ok;
        logic [7:0] st, v;
        logic [15:0] d, e;
        logic [35:0] a;
        rd_log.delete(); exp_rd_q.delete();
        wr_reg(3'd2, 8'h02); wr_reg(3'd3, 8'h10); wr_reg(3'd4, 8'h00);
        wr_reg(3'd5, 8'h00); wr_reg(3'd6, 8'hE0);
        wr_reg(3'd7, 8'h20);
        for (int s = 0; s < 2; s++) begin
            wait_status(8'h88, 8'h08, 4000, ok, st);
            n_checks++; if (!ok || st !== 8'h58) begin n_fail++; $display("FAIL read_drq%0d: status %h ok %0d want 58", s, st, ok); end
            for (int i = 0; i < 256; i++) begin
                host_rd(2'b10, 3'd0, d);
                n_checks++;
                if (exp_rd_q.size() == 0) begin
                    n_fail++; $display("FAIL read_word s%0d w%0d: got %h with no word served", s, i, d);
                end else begin
                    e = exp_rd_q.pop_front();
                    if (d !== e) begin n_fail++; $display("FAIL read_word s%0d w%0d: got %h want %h", s, i, d, e); end
                end
            end
        end
        wait_status(8'h88, 8'h00, 4000, ok, st);
        n_checks++; if (!ok || st !== 8'h50) begin n_fail++; $display("FAIL read_done: status %h want 50", st); end
        n_checks++; if (rd_log.size() != 512) begin n_fail++; $display("FAIL read_count: %0d mem reads want 512", rd_log.size()); end
        for (int i = 0; i < 512 && rd_log.size() > 0; i++) begin
            a = rd_log.pop_front();
            n_checks++;
            if (a !== {28'h10 + 28'(i / 256), 8'(i % 256)}) begin
                n_fail++; $display("FAIL read_addr %0d: lba %h word %h want lba %h word %h", i, a[35:8], a[7:0], 28'h10 + 28'(i / 256), 8'(i % 256));
            end
        end
        rd_reg(3'd2, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL read_endcount: got %h want 00", v); end
        rd_reg(3'd3, v);
        n_checks++; if (v !== 8'h12) begin n_fail++; $display("FAIL read_endlba: got %h want 12", v); end
    endtask

    task automatic test_write;
        logic ok;
        logic [7:0] st, v;
        logic [15:0] w, w0, d;
        logic [51:0] g, e;
        wr_log.delete(); exp_wr_q.delete();
        wr_reg(3'd2, 8'h01); wr_reg(3'd3, 8'hEF); wr_reg(3'd4, 8'hCD);
        wr_reg(3'd5, 8'hAB); wr_reg(3'd6, 8'hE5);
        wr_reg(3'd7, 8'h30);
        rd_reg(3'd7, st);
        n_checks++; if (st !== 8'h58) begin n_fail++; $display("FAIL write_drq: status %h want 58", st); end
        wr_reg(3'd2, 8'h55);
        rd_reg(3'd2, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL write_tf_locked: count %h want 01", v); end
        w0 = 16'h0;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (i == 0) w0 = w;
            exp_wr_q.push_back({28'h5ABCDEF, 8'(i), w});
            host_wr(2'b10, 3'd0, w);
        end
        wait_status(8'h88, 8'h00, 4000, ok, st);
        n_checks++; if (!ok || st !== 8'h50) begin n_fail++; $display("FAIL write_done: status %h want 50", st); end
        n_checks++; if (wr_log.size() != 256) begin n_fail++; $display("FAIL write_count: %0d mem writes want 256", wr_log.size()); end
        while (wr_log.size() > 0 && exp_wr_q.size() > 0) begin
            g = wr_log.pop_front();
            e = exp_wr_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL write_store: got %h want %h", g, e); end
        end
        host_rd(2'b10, 3'd0, d);
        n_checks++; if (d !== w0) begin n_fail++; $display("FAIL idle_data0: got %h want %h", d, w0); end
        host_rd(2'b10, 3'd0, d);
        n_checks++; if (d !== w0) begin n_fail++; $display("FAIL idle_data1: got %h want %h", d, w0); end
        rd_reg(3'd3, v);
        n_checks++; if (v !== 8'hF0) begin n_fail++; $display("FAIL write_endlba: got %h want f0", v); end
    endtask

    task automatic test_abort_srst;
        logic [7:0] st, v;
        logic [15:0] d;
        wr_reg(3'd7, 8'hC8);
        rd_reg(3'd7, st);
        n_checks++; if (st !== 8'h51) begin n_fail++; $display("FAIL abort_status: got %h want 51", st); end
        rd_reg(3'd1, v);
        n_checks++; if (v !== 8'h04) begin n_fail++; $display("FAIL abort_error: got %h want 04", v); end
        wr_reg(3'd2, 8'h01);
        wr_reg(3'd7, 8'h20);
        rd_reg(3'd7, st);
        n_checks++; if (st[0] !== 1'b0) begin n_fail++; $display("FAIL abort_clear: status %h want err bit 0", st); end
        rd_reg(3'd1, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL abort_clear_err: got %h want 00", v); end
        host_wr(2'b01, 3'd6, 16'h0004);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL srst_req: mem_req %b want 0", mem_req); end
        host_rd(2'b01, 3'd6, d);
        n_checks++; if (d[7:0] !== 8'hD0) begin n_fail++; $display("FAIL srst_status: got %h want d0", d[7:0]); end
        host_wr(2'b01, 3'd6, 16'h0000);
        rd_reg(3'd7, st);
        n_checks++; if (st !== 8'h50) begin n_fail++; $display("FAIL srst_done: got %h want 50", st); end
        rd_reg(3'd1, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL srst_error: got %h want 01", v); end
        rd_log.delete(); exp_rd_q.delete();
    endtask

    task automatic test_timeout;
        logic ok;
        logic [7:0] st, v;
        int unsigned t0;
        mem_en = 1'b0;
        wr_reg(3'd2, 8'h01);
        wr_reg(3'd7, 8'h20);
        t0 = cyc;
        wait_status(8'h80, 8'h00, MEM_LAT_MAX + 2000, ok, st);
        n_checks++; if (!ok || (cyc - t0) < MEM_LAT_MAX) begin n_fail++; $display("FAIL timeout_time: %0d cycles ok %0d want >= %0d", cyc - t0, ok, MEM_LAT_MAX); end
        n_checks++; if (st !== 8'h51) begin n_fail++; $display("FAIL timeout_status: got %h want 51", st); end
        rd_reg(3'd1, v);
        n_checks++; if (v !== 8'h10) begin n_fail++; $display("FAIL timeout_error: got %h want 10", v); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_req: mem_req %b want 0", mem_req); end
        mem_en = 1'b1;
    endtask

    task automatic test_identify;
        logic [7:0] st, v;
        rd_log.delete();
        wr_reg(3'd7, 8'hEC);
        rd_reg(3'd7, st);
`ifdef IDE_IDENTIFY_EN
        begin
            logic [15:0] w [256];
            n_checks++; if (st !== 8'h58) begin n_fail++; $display("FAIL ident_drq: got %h want 58", st); end
            for (int i = 0; i < 256; i++) host_rd(2'b10, 3'd0, w[i]);
            n_checks++; if (w[49][9] !== 1'b1) begin n_fail++; $display("FAIL ident_w49: got %h want bit9 set", w[49]); end
            n_checks++; if (w[60] !== 16'hFFFF) begin n_fail++; $display("FAIL ident_w60: got %h want ffff", w[60]); end
            n_checks++; if (w[61] !== 16'h0FFF) begin n_fail++; $display("FAIL ident_w61: got %h want 0fff", w[61]); end
            rd_reg(3'd7, st);
            n_checks++; if (st !== 8'h50) begin n_fail++; $display("FAIL ident_done: got %h want 50", st); end
            n_checks++; if (rd_log.size() != 0) begin n_fail++; $display("FAIL ident_mem: %0d mem reads want 0", rd_log.size()); end
            v = 8'h00;
        end
`else
        n_checks++; if (st !== 8'h51) begin n_fail++; $display("FAIL ident_abort: got %h want 51", st); end
        rd_reg(3'd1, v);
        n_checks++; if (v !== 8'h04) begin n_fail++; $display("FAIL ident_error: got %h want 04", v); end
`endif
    endtask

    initial begin
        reset_n = 1'b0; ide_dior = 1'b1; ide_diow = 1'b1; ide_cs = 2'b11; ide_da = 3'd0;
        host_data = 16'h0; host_oe = 1'b0; mem_en = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_read();
        test_write();
        test_abort_srst();
        test_timeout();
        test_identify();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
